// File: rtl/xbus_pkg.sv
// xbus_pkg: shared types and widths for the xbus arbiter slice.
//   - xbus_state_e : arbiter FSM states (IDLE, XFER, ACK)
//   - XBUS_AW/DW/BW: address, data and byte-enable widths
//   - mst_idx_t    : master index (0 = CPU data port, 1 = debug/loader)
//   - xbus_req_t   : latched request payload driven onto the xbus
package xbus_pkg;

  localparam int unsigned XBUS_AW = 32;
  localparam int unsigned XBUS_DW = 32;
  localparam int unsigned XBUS_BW = 4;
  localparam int unsigned WCNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_ACK  = 2'd2
  } xbus_state_e;

  typedef logic mst_idx_t;

  typedef struct packed {
    logic               we;
    logic [XBUS_BW-1:0] be;
    logic [XBUS_AW-1:0] addr;
    logic [XBUS_DW-1:0] wdata;
  } xbus_req_t;

  // Two-way round-robin choice: on a tie the master that did not go last wins.
  function automatic mst_idx_t rr_pick2(input logic [1:0] req, input mst_idx_t last_grant);
    if (req == 2'b11) begin
      return ~last_grant;
    end
    return req[1] ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/xbus_rr_pick2.sv
// xbus_rr_pick2: combinational two-way round-robin pick.
//   req[1:0]   in  request per master
//   last_grant in  master granted most recently
//   gnt_valid  out at least one request present
//   gnt_idx    out chosen master (meaningful only when gnt_valid)
module xbus_rr_pick2
  import xbus_pkg::*;
(
  input  logic [1:0] req,
  input  mst_idx_t   last_grant,
  output logic       gnt_valid,
  output mst_idx_t   gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = rr_pick2(req, last_grant);
  end

endmodule

// File: rtl/xbus_arbiter.sv
// xbus_arbiter: shares the single xbus peripheral port between master 0
// (CPU data) and master 1 (debug/loader) with round-robin fairness.
//   clk, rst_n           clock, async active-low reset
//   m*_req/we/be/addr/wdata  master request fields (req held until ack)
//   m*_ack, m*_rdata     one-cycle completion pulse and read data
//   xbus_cs/we/be/addr/wdata registered peripheral request
//   xbus_rdata           combinational read data from the peripheral
// WAIT_CYCLES (0..15) extends xbus_cs beyond its first cycle.
module xbus_arbiter
  import xbus_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               m0_req,
  input  logic               m0_we,
  input  logic [XBUS_BW-1:0] m0_be,
  input  logic [XBUS_AW-1:0] m0_addr,
  input  logic [XBUS_DW-1:0] m0_wdata,
  output logic               m0_ack,
  output logic [XBUS_DW-1:0] m0_rdata,
  input  logic               m1_req,
  input  logic               m1_we,
  input  logic [XBUS_BW-1:0] m1_be,
  input  logic [XBUS_AW-1:0] m1_addr,
  input  logic [XBUS_DW-1:0] m1_wdata,
  output logic               m1_ack,
  output logic [XBUS_DW-1:0] m1_rdata,
  output logic               xbus_cs,
  output logic               xbus_we,
  output logic [XBUS_BW-1:0] xbus_be,
  output logic [XBUS_AW-1:0] xbus_addr,
  output logic [XBUS_DW-1:0] xbus_wdata,
  input  logic [XBUS_DW-1:0] xbus_rdata
);

  localparam logic [WCNT_W-1:0] WAIT_LD = WCNT_W'(WAIT_CYCLES);

  xbus_state_e        state_q, state_d;
  logic [WCNT_W-1:0]  cnt_q, cnt_d;
  mst_idx_t           last_grant_q, last_grant_d;
  mst_idx_t           owner_q, owner_d;
  xbus_req_t          bus_q, bus_d;
  logic               cs_q, cs_d;
  logic               m0_ack_q, m0_ack_d;
  logic               m1_ack_q, m1_ack_d;
  logic [XBUS_DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [XBUS_DW-1:0] m1_rdata_q, m1_rdata_d;

  logic               gnt_valid;
  mst_idx_t           gnt_idx;
  xbus_req_t          m0_payload, m1_payload;

  // Master request payloads, packed for a single latch on grant.
  always_comb begin
    m0_payload = '{we: m0_we, be: m0_be, addr: m0_addr, wdata: m0_wdata};
    m1_payload = '{we: m1_we, be: m1_be, addr: m1_addr, wdata: m1_wdata};
  end

  xbus_rr_pick2 u_pick (
    .req       ({m1_req, m0_req}),
    .last_grant(last_grant_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    bus_d        = bus_q;
    cs_d         = cs_q;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          owner_d      = gnt_idx;
          last_grant_d = gnt_idx;
          bus_d        = gnt_idx ? m1_payload : m0_payload;
          cnt_d        = WAIT_LD;
          cs_d         = 1'b1;
          state_d      = ST_XFER;
        end
      end
      ST_XFER: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WCNT_W'(1);
        end else begin
          // Capture on the last cs cycle; the owner's rdata register doubles
          // as the capture register so data is valid alongside the ack.
          cs_d    = 1'b0;
          state_d = ST_ACK;
          if (owner_q) begin
            m1_ack_d   = 1'b1;
            m1_rdata_d = xbus_rdata;
            m0_rdata_d = '0;
          end else begin
            m0_ack_d   = 1'b1;
            m0_rdata_d = xbus_rdata;
            m1_rdata_d = '0;
          end
        end
      end
      ST_ACK: begin
        // Requests are not evaluated here: a req still high belongs to the
        // transfer just acknowledged.
        m0_rdata_d = '0;
        m1_rdata_d = '0;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cs_d    = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      bus_q        <= '0;
      cs_q         <= 1'b0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      bus_q        <= bus_d;
      cs_q         <= cs_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  assign xbus_cs    = cs_q;
  assign xbus_we    = bus_q.we;
  assign xbus_be    = bus_q.be;
  assign xbus_addr  = bus_q.addr;
  assign xbus_wdata = bus_q.wdata;
  assign m0_ack     = m0_ack_q;
  assign m1_ack     = m1_ack_q;
  assign m0_rdata   = m0_rdata_q;
  assign m1_rdata   = m1_rdata_q;

endmodule

// File: tb/tb_xbus_arbiter.sv
// Testbench for xbus_arbiter: two instances (WAIT_CYCLES 0 and 3) share the
// master-side stimulus; each directed step observes one of them.
module tb_xbus_arbiter;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

  logic        m0_ack   [2];
  logic        m1_ack   [2];
  logic [31:0] m0_rdata [2];
  logic [31:0] m1_rdata [2];
  logic        xbus_cs  [2];
  logic        xbus_we  [2];
  logic [3:0]  xbus_be  [2];
  logic [31:0] xbus_addr  [2];
  logic [31:0] xbus_wdata [2];
  logic [31:0] rdata_in   [2];

  logic [7:0]  led = 8'h00;
  int          both_cnt = 0;
  int          tests = 0;
  int          fails = 0;
  exp_t        sb[$];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    xbus_arbiter #(.WAIT_CYCLES(k * 3)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .m0_req    (m0_req),
      .m0_we     (m0_we),
      .m0_be     (m0_be),
      .m0_addr   (m0_addr),
      .m0_wdata  (m0_wdata),
      .m0_ack    (m0_ack[k]),
      .m0_rdata  (m0_rdata[k]),
      .m1_req    (m1_req),
      .m1_we     (m1_we),
      .m1_be     (m1_be),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m1_ack    (m1_ack[k]),
      .m1_rdata  (m1_rdata[k]),
      .xbus_cs   (xbus_cs[k]),
      .xbus_we   (xbus_we[k]),
      .xbus_be   (xbus_be[k]),
      .xbus_addr (xbus_addr[k]),
      .xbus_wdata(xbus_wdata[k]),
      .xbus_rdata(rdata_in[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LED peripheral on the WAIT_CYCLES=0 instance: byte lane 0 write.
  always @(posedge clk) begin
    if (xbus_cs[0] && xbus_we[0] && xbus_be[0][0]) led <= xbus_wdata[0][7:0];
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (m0_ack[k] && m1_ack[k]) both_cnt <= both_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_master(input int idx, input logic req, input logic we,
                            input logic [3:0] be, input logic [31:0] addr,
                            input logic [31:0] wdata);
    if (idx == 0) begin
      m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wdata; m0_req = req;
    end else begin
      m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wdata; m1_req = req;
    end
  endtask

  // One transfer from a single master, observed on instance sel.
  task automatic do_xfer(input int sel, input int idx, input logic we,
                         input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rd_base,
                         input bit vary, input bit addr_chg, input string tag);
    int          w = (sel == 1) ? 3 : 0;
    int          cyc = 0;
    int          cs_cnt = 0;
    bit          got = 0;
    bit          addr_bad = 0;
    bit          other_ack = 0;
    logic        cap_we = 1'b0;
    logic [3:0]  cap_be = 4'h0;
    logic [31:0] cap_addr = 32'h0;
    logic [31:0] cap_wdata = 32'h0;
    logic [31:0] obs_rd = 32'h0;
    logic [31:0] oth_rd = 32'h0;
    exp_t        e;
    e.idx   = idx;
    e.rdata = vary ? (rd_base ^ 32'(w + 1)) : rd_base;
    sb.push_back(e);
    rdata_in[0] = rd_base;
    rdata_in[1] = rd_base;
    set_master(idx, 1'b1, we, be, addr, wdata);
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (xbus_cs[sel]) begin
        cs_cnt++;
        if (cs_cnt == 1) begin
          cap_we = xbus_we[sel]; cap_be = xbus_be[sel];
          cap_addr = xbus_addr[sel]; cap_wdata = xbus_wdata[sel];
        end else if (xbus_addr[sel] !== cap_addr) begin
          addr_bad = 1;
        end
        if (vary) rdata_in[sel] = rd_base ^ 32'(cs_cnt);
        if (addr_chg && cs_cnt == 1) m0_addr = 32'h8;
      end
      if ((idx == 0 ? m1_ack[sel] : m0_ack[sel]) === 1'b1) other_ack = 1;
      if ((idx == 0 ? m0_ack[sel] : m1_ack[sel]) === 1'b1) begin
        got    = 1;
        obs_rd = (idx == 0) ? m0_rdata[sel] : m1_rdata[sel];
        oth_rd = (idx == 0) ? m1_rdata[sel] : m0_rdata[sel];
      end
    end
    check({tag, "_ack_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(w + 2));
    check({tag, "_cs_len"}, 32'(cs_cnt), 32'(w + 1));
    check({tag, "_addr"}, cap_addr, addr);
    check({tag, "_addr_stable"}, 32'(addr_bad), 32'd0);
    check({tag, "_we"}, 32'(cap_we), 32'(we));
    check({tag, "_be"}, 32'(cap_be), 32'(be));
    if (we) check({tag, "_wdata"}, cap_wdata, wdata);
    e = sb.pop_front();
    check({tag, "_rdata"}, obs_rd, e.rdata);
    check({tag, "_other_ack"}, 32'(other_ack), 32'd0);
    check({tag, "_other_rdata"}, oth_rd, 32'h0);
    set_master(idx, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int   cyc;
    bit   seen;
    rst_n = 1'b0;
    m0_req = 0; m0_we = 0; m0_be = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_be = 0; m1_addr = 0; m1_wdata = 0;
    rdata_in[0] = 32'h0;
    rdata_in[1] = 32'h0;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_cs", 32'(xbus_cs[0]), 32'd0);
    check("rst_we", 32'(xbus_we[0]), 32'd0);
    check("rst_be", 32'(xbus_be[0]), 32'd0);
    check("rst_addr", xbus_addr[0], 32'h0);
    check("rst_wdata", xbus_wdata[0], 32'h0);
    check("rst_acks", 32'({m0_ack[0], m1_ack[0], m0_ack[1], m1_ack[1]}), 32'd0);
    check("rst_rdata", m0_rdata[0] | m1_rdata[0], 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single m0 read, WAIT_CYCLES=0.
    do_xfer(0, 0, 1'b0, 4'hF, 32'h0, 32'h0, 32'h00A5_003C, 1'b0, 1'b0, "m0_rd_w0");

    // m1 write to the LED peripheral.
    do_xfer(0, 1, 1'b1, 4'b0001, 32'h10, 32'h0000_00FF, 32'h1111_2222, 1'b0, 1'b0, "m1_wr_w0");
    check("led_value", 32'(led), 32'h0000_00FF);

    // WAIT_CYCLES=3 read with xbus_rdata changing every cs cycle.
    do_xfer(1, 0, 1'b0, 4'hF, 32'h40, 32'h0, 32'hCAFE_0000, 1'b1, 1'b0, "m0_rd_w3");

    // Master address changes after grant; latched address must hold.
    do_xfer(1, 0, 1'b0, 4'hF, 32'h4, 32'h0, 32'h5555_AAAA, 1'b0, 1'b1, "addr_chg");

    // Continuous contention from reset: strict 0,1,0,1,0,1.
    rst_n = 1'b0;
    rdata_in[0] = 32'h0BAD_F00D;
    rdata_in[1] = 32'h0BAD_F00D;
    set_master(0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    set_master(1, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
    for (int t = 0; t < 6; t++) begin
      e.idx = t % 2;
      e.rdata = 32'h0BAD_F00D;
      sb.push_back(e);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      cyc  = 0;
      seen = 0;
      while (!seen && cyc < 20) begin
        @(negedge clk);
        cyc++;
        if (m0_ack[0] === 1'b1 || m1_ack[0] === 1'b1) seen = 1;
      end
      check($sformatf("rr_ack_seen_%0d", t), 32'(seen), 32'd1);
      e = sb.pop_front();
      check($sformatf("rr_grant_%0d", t), (m1_ack[0] === 1'b1) ? 32'd1 : 32'd0, 32'(e.idx));
      check($sformatf("rr_rdata_%0d", t), (m1_ack[0] === 1'b1) ? m1_rdata[0] : m0_rdata[0], e.rdata);
    end
    set_master(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_master(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (8) @(negedge clk);

    // Reset during the second XFER cycle, WAIT_CYCLES=3.
    set_master(0, 1'b1, 1'b0, 4'hF, 32'h30, 32'h0);
    repeat (2) @(negedge clk);
    check("abort_cs_before", 32'(xbus_cs[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_cs", 32'(xbus_cs[1]), 32'd0);
    check("abort_addr", xbus_addr[1], 32'h0);
    check("abort_be_we", 32'({xbus_be[1], xbus_we[1]}), 32'd0);
    check("abort_acks", 32'({m0_ack[1], m1_ack[1]}), 32'd0);
    check("abort_rdata", m0_rdata[1] | m1_rdata[1], 32'h0);
    m0_req = 1'b0;
    seen = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (m0_ack[1] === 1'b1) seen = 1;
    end
    check("abort_no_ack", 32'(seen), 32'd0);
    do_xfer(1, 1, 1'b0, 4'hF, 32'h50, 32'h0, 32'h7777_0001, 1'b0, 1'b0, "after_abort_m1");

    check("never_both_acks", 32'(both_cnt), 32'd0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
